// File: rtl/lcd_pkg.sv
// lcd_pkg: shared bus fields, opcode masks, addresses and AC helpers for the HD44780 responder
package lcd_pkg;

    localparam int RS_BIT = 10;
    localparam int RW_BIT = 9;
    localparam int E_BIT  = 8;

    localparam int NUM_CELLS = 32;

    localparam logic [7:0] CMD_SET_AC = 8'h80;
    localparam logic [7:0] CMD_CGRAM  = 8'h40;
    localparam logic [7:0] CMD_FUNC   = 8'h20;
    localparam logic [7:0] CMD_SHIFT  = 8'h10;
    localparam logic [7:0] CMD_DISP   = 8'h08;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h01;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    localparam logic [7:0] FILL_CHAR = 8'h20;

    typedef enum logic [1:0] {
        INIT_FILL,
        IDLE,
        EXEC,
        CLEAR_FILL
    } state_e;

    // Only 0x00-0x0F and 0x40-0x4F exist on a 2x16 panel
    function automatic logic ac_legal(input logic [6:0] ac);
        return (ac & ~(LINE1_BASE | 7'h0F)) == 7'h00;
    endfunction

    function automatic logic [4:0] ac_idx(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

    // Step within a 16-column line; leaving either end of a line lands on the other line
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [3:0] col;
        logic       wrap;
        col  = inc ? ac[3:0] + 4'd1 : ac[3:0] - 4'd1;
        wrap = inc ? &ac[3:0] : ~|ac[3:0];
        return ((ac[6] ^ wrap) ? LINE1_BASE : LINE0_BASE) | {3'b000, col};
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 32x8 display RAM, one synchronous write port, two combinational read ports
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [4:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [4:0] raddr_a_i,
    output logic [7:0] rdata_a_o,
    input  logic [4:0] raddr_b_i,
    output logic [7:0] rdata_b_o
);

    logic [7:0] mem_q [NUM_CELLS];

    // Contents are initialised by the fill sequence, so the array carries no reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: decodes E-strobed LCD bus words into a 2x16 DDRAM image with busy timing
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] lcd_word,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [6:0]  cursor,
    output logic        display_on,
    output logic        two_line,
    output logic [7:0]  cmd_count,
    output logic        err,
    input  logic [4:0]  dbg_idx,
    output logic [7:0]  dbg_char
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fill_q, fill_d;
    logic [6:0]  ac_q, ac_d;
    logic        id_q, id_d;
    logic        disp_q, disp_d;
    logic        two_q, two_d;
    logic [7:0]  cmdc_q, cmdc_d;
    logic        err_q, err_d;
    logic [7:0]  rdd_q, rdd_d;
    logic        rdv_q, rdv_d;
    logic        e_q, rs_q, rw_q;
    logic [7:0]  d_q;
    logic        strobe;
    logic        we;
    logic [4:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  cell_ac;

    lcd_ddram u_ddram (
        .clk       (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (ac_idx(ac_q)),
        .rdata_a_o (cell_ac),
        .raddr_b_i (dbg_idx),
        .rdata_b_o (dbg_char)
    );

    assign strobe = e_q & ~lcd_word[E_BIT];
    assign busy   = state_q != IDLE;

    // Bus fields are registered every cycle so a falling E sees the last high-E word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q  <= 1'b0;
            rs_q <= 1'b0;
            rw_q <= 1'b0;
            d_q  <= 8'h00;
        end else begin
            e_q  <= lcd_word[E_BIT];
            rs_q <= lcd_word[RS_BIT];
            rw_q <= lcd_word[RW_BIT];
            d_q  <= lcd_word[7:0];
        end
    end

    // Next state: fill/busy sequencing, then strobe decode which may start a new busy period
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        ac_d    = ac_q;
        id_d    = id_q;
        disp_d  = disp_q;
        two_d   = two_q;
        cmdc_d  = cmdc_q;
        err_d   = err_q;
        rdd_d   = rdd_q;
        rdv_d   = 1'b0;
        we      = 1'b0;
        waddr   = cnt_q[4:0];
        wdata   = FILL_CHAR;
        case (state_q)
            INIT_FILL: begin
                we    = 1'b1;
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'(NUM_CELLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'(BUSY_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            CLEAR_FILL: begin
                we    = fill_q && cnt_q < 16'(NUM_CELLS);
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'(CLEAR_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        if (strobe) begin
            cmdc_d = cmdc_q + 8'd1;
            if (rw_q) begin
                rdv_d = 1'b1;
                rdd_d = rs_q ? cell_ac : {busy, ac_q};
                if (rs_q) ac_d = ac_step(ac_q, id_q);
            end else if (busy) begin
                err_d = 1'b1;
            end else begin
                state_d = EXEC;
                cnt_d   = '0;
                if (rs_q) begin
                    we    = 1'b1;
                    waddr = ac_idx(ac_q);
                    wdata = d_q;
                    ac_d  = ac_step(ac_q, id_q);
                end else if (|(d_q & CMD_SET_AC)) begin
                    ac_d  = ac_legal(d_q[6:0]) ? d_q[6:0] : LINE0_BASE;
                    err_d = err_q | ~ac_legal(d_q[6:0]);
                end else if (|(d_q & CMD_CGRAM)) begin
                end else if (|(d_q & CMD_FUNC)) begin
                    two_d = d_q[3];
                end else if (|(d_q & CMD_SHIFT)) begin
                end else if (|(d_q & CMD_DISP)) begin
                    disp_d = d_q[2];
                end else if (|(d_q & CMD_ENTRY)) begin
                    id_d = d_q[1];
                end else if (|(d_q & CMD_HOME)) begin
                    ac_d    = LINE0_BASE;
                    state_d = CLEAR_FILL;
                    fill_d  = 1'b0;
                end else if (|(d_q & CMD_CLEAR)) begin
                    ac_d    = LINE0_BASE;
                    id_d    = 1'b1;
                    state_d = CLEAR_FILL;
                    fill_d  = 1'b1;
                end
            end
        end
    end

    // State and architectural registers; reset restarts the power-up fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT_FILL;
            cnt_q   <= '0;
            fill_q  <= 1'b1;
            ac_q    <= LINE0_BASE;
            id_q    <= 1'b1;
            disp_q  <= 1'b0;
            two_q   <= 1'b0;
            cmdc_q  <= 8'h00;
            err_q   <= 1'b0;
            rdd_q   <= 8'h00;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            ac_q    <= ac_d;
            id_q    <= id_d;
            disp_q  <= disp_d;
            two_q   <= two_d;
            cmdc_q  <= cmdc_d;
            err_q   <= err_d;
            rdd_q   <= rdd_d;
            rdv_q   <= rdv_d;
        end
    end

    assign rd_data    = rdd_q;
    assign rd_valid   = rdv_q;
    assign cursor     = ac_q;
    assign display_on = disp_q;
    assign two_line   = two_q;
    assign cmd_count  = cmdc_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed plus random bus traffic checked against a behavioural panel model
module tb_lcd_hd44780_responder;

    localparam int B = 8;
    localparam int C = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] lcd_word = '0;
    logic [4:0]  dbg_idx = '0;
    logic        busy, rd_valid, display_on, two_line, err;
    logic [7:0]  rd_data, cmd_count, dbg_char;
    logic [6:0]  cursor;

    int checks = 0;
    int fails = 0;

    lcd_hd44780_responder #(.BUSY_CYCLES(B), .CLEAR_CYCLES(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_word   (lcd_word),
        .busy       (busy),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .cursor     (cursor),
        .display_on (display_on),
        .two_line   (two_line),
        .cmd_count  (cmd_count),
        .err        (err),
        .dbg_idx    (dbg_idx),
        .dbg_char   (dbg_char)
    );

    always #5 clk = ~clk;

    // Panel model: cursor as (line, column), busy as cycles remaining
    logic [7:0]  m_mem [32];
    bit          m_known [32];
    int          busy_left, fill_pos, line, col;
    bit          filling, m_id, m_disp, m_two, m_err, m_rdv, m_rdd_ok;
    logic [7:0]  m_cnt, m_rdd;
    logic [10:0] prev_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] m_cursor(input int l, input int c);
        return 7'(l * 64 + c);
    endfunction

    task automatic m_step(input bit inc);
        if (inc) begin
            col++;
            if (col == 16) begin col = 0; line ^= 1; end
        end else begin
            col--;
            if (col < 0) begin col = 15; line ^= 1; end
        end
    endtask

    task automatic model_step();
        logic [10:0] w;
        bit          was_busy, nf;
        int          nb, msb, v;
        if (!reset) begin
            busy_left = 32; fill_pos = 0; filling = 1; line = 0; col = 0;
            m_id = 1; m_disp = 0; m_two = 0; m_err = 0; m_cnt = 0;
            m_rdd = 0; m_rdd_ok = 1; m_rdv = 0; prev_w = 0;
            return;
        end
        w = prev_w;
        prev_w = lcd_word;
        was_busy = busy_left > 0;
        m_rdv = 0;
        nb = 0;
        nf = 0;
        if (w[8] && !lcd_word[8]) begin
            m_cnt++;
            if (w[9]) begin
                m_rdv = 1;
                if (w[10]) begin
                    m_rdd = m_mem[line * 16 + col];
                    m_rdd_ok = m_known[line * 16 + col];
                    m_step(m_id);
                end else begin
                    m_rdd = {was_busy, m_cursor(line, col)};
                    m_rdd_ok = 1;
                end
            end else if (was_busy) begin
                m_err = 1;
            end else if (w[10]) begin
                m_mem[line * 16 + col] = w[7:0];
                m_known[line * 16 + col] = 1;
                m_step(m_id);
                nb = B;
            end else begin
                msb = -1;
                for (int i = 0; i < 8; i++) if (w[i]) msb = i;
                nb = B;
                case (msb)
                    7: begin
                        v = int'(w[6:0]);
                        if (v < 16) begin line = 0; col = v; end
                        else if (v >= 64 && v < 80) begin line = 1; col = v - 64; end
                        else begin line = 0; col = 0; m_err = 1; end
                    end
                    5: m_two = w[3];
                    3: m_disp = w[2];
                    2: m_id = w[1];
                    1: begin line = 0; col = 0; nb = C; nf = 0; end
                    0: begin line = 0; col = 0; m_id = 1; nb = C; nf = 1; end
                    default: ;
                endcase
            end
        end
        if (was_busy) begin
            if (filling && fill_pos < 32) begin
                m_mem[fill_pos] = 8'h20;
                m_known[fill_pos] = 1;
                fill_pos++;
            end
            busy_left--;
        end
        if (nb > 0) begin
            busy_left = nb;
            fill_pos = 0;
            filling = nf;
        end
    endtask

    // Model advance and full output compare once per cycle, away from the active edge
    initial begin
        for (int i = 0; i < 32; i++) m_known[i] = 0;
        forever begin
            @(negedge clk);
            model_step();
            chk("busy", busy, busy_left > 0);
            chk("cursor", cursor, m_cursor(line, col));
            chk("display_on", display_on, m_disp);
            chk("two_line", two_line, m_two);
            chk("cmd_count", cmd_count, m_cnt);
            chk("err", err, m_err);
            chk("rd_valid", rd_valid, m_rdv);
            if (m_rdd_ok) chk("rd_data", rd_data, m_rdd);
            if (m_known[dbg_idx]) chk("dbg_char", dbg_char, m_mem[dbg_idx]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input bit rs, input bit rw, input logic [7:0] d);
        lcd_word = {rs, rw, 1'b1, d};
        tick();
        lcd_word = {2'($urandom), 1'b0, 8'($urandom)};
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_left > 0 && n < 500) begin tick(); n++; end
        if (busy_left > 0) begin
            checks++;
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        wait_idle();
        send(1'b0, 1'b0, d);
    endtask

    task automatic wr_dat(input logic [7:0] d);
        wait_idle();
        send(1'b1, 1'b0, d);
    endtask

    task automatic chk_cell(input int idx, input logic [7:0] exp);
        dbg_idx = 5'(idx);
        #1;
        chk($sformatf("cell%0d", idx), dbg_char, exp);
        chk($sformatf("model_cell%0d", idx), m_mem[idx], exp);
    endtask

    task automatic busy_len(input string name, input int exp);
        int k = 0;
        while (busy && k < 500) begin k++; tick(); end
        chk(name, k, exp);
    endtask

    task automatic init_len(input string name);
        int k = 0;
        do begin tick(); k++; end while (busy && k < 100);
        chk(name, k, 32);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 1);
        chk("rst_cursor", cursor, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", err, 0);
        chk("rst_display_on", display_on, 0);
        chk("rst_two_line", two_line, 0);
        reset = 1'b1;
        init_len("init_busy_len");
        for (int i = 0; i < 32; i++) begin chk_cell(i, 8'h20); tick(); end
        chk("init_cursor", cursor, 7'h00);

        wr_cmd(8'h8E);
        wr_dat(8'h41);
        wr_dat(8'h42);
        wr_dat(8'h43);
        wait_idle();
        chk_cell(14, 8'h41);
        chk_cell(15, 8'h42);
        chk_cell(16, 8'h43);
        chk("wrap_cursor", cursor, 7'h41);

        wr_cmd(8'h04);
        wr_cmd(8'h80);
        wr_dat(8'h5A);
        wait_idle();
        chk_cell(0, 8'h5A);
        chk("dec_cursor", cursor, 7'h4F);

        wr_dat(8'h58);
        send(1'b1, 1'b0, 8'h58);
        wait_idle();
        chk_cell(31, 8'h58);
        chk_cell(30, 8'h20);
        chk("viol_err", err, 1);
        chk("viol_cmd_count", cmd_count, 9);
        chk("viol_cursor", cursor, 7'h4E);

        wr_dat(8'h51);
        while (busy_left > 1) tick();
        send(1'b1, 1'b0, 8'h52);
        busy_len("write_busy_len", B);
        chk_cell(30, 8'h51);
        chk_cell(29, 8'h52);
        chk("b2b_cursor", cursor, 7'h4C);
        chk("b2b_cmd_count", cmd_count, 11);

        wr_cmd(8'h01);
        busy_len("clear_busy_len", C);
        for (int i = 0; i < 32; i++) begin chk_cell(i, 8'h20); tick(); end
        chk("clear_cursor", cursor, 7'h00);

        wr_dat(8'h48);
        wr_dat(8'h49);
        wr_cmd(8'h01);
        send(1'b0, 1'b1, 8'h00);
        chk("clear_bf_read", rd_data, 8'h80);
        chk("clear_bf_valid", rd_valid, 1);
        chk("clear_read_count", cmd_count, 16);

        tick();
        reset = 1'b0;
        tick();
        chk("midreset_busy", busy, 1);
        chk("midreset_count", cmd_count, 0);
        reset = 1'b1;
        init_len("reinit_busy_len");

        wr_cmd(8'h38);
        wr_cmd(8'h0C);
        wr_cmd(8'h06);
        wr_cmd(8'h01);
        wr_dat(8'h48);
        wr_dat(8'h4F);
        wr_dat(8'h4C);
        wr_dat(8'h41);
        wait_idle();
        chk("seq_two_line", two_line, 1);
        chk("seq_display_on", display_on, 1);
        chk_cell(0, 8'h48);
        chk_cell(1, 8'h4F);
        chk_cell(2, 8'h4C);
        chk_cell(3, 8'h41);
        chk("seq_cmd_count", cmd_count, 8);
        chk("seq_err", err, 0);
        chk("seq_cursor", cursor, 7'h04);

        for (int t = 0; t < 600; t++) begin
            int gap;
            int hold;
            gap = $urandom_range(0, 12);
            repeat (gap) begin dbg_idx = 5'($urandom); tick(); end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                tick();
                tick();
                reset = 1'b1;
            end
            hold = $urandom_range(1, 3);
            repeat (hold) begin
                lcd_word = {2'($urandom), 1'b1, 8'($urandom)};
                dbg_idx = 5'($urandom);
                tick();
            end
            lcd_word = {2'($urandom), 1'b0, 8'($urandom)};
            tick();
        end
        repeat (C + 5) begin dbg_idx = 5'($urandom); tick(); end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

Behavioural responder for the 11-bit LCD instruction bus produced by the LCD sequencer. It sits on the sequencer's `salida` output in simulation and FPGA self-test builds. It decodes each E-strobed word as an HD44780-style command or data write, maintains a 2x16 DDRAM image, the cursor and the busy timing, and flags protocol violations. It is the receiving end of that bus; it lets the sequencer and its instruction tables be checked without a physical panel.

## Interface
Parameters:
- `BUSY_CYCLES`, 40: busy duration after any command or data write except clear and home.
- `CLEAR_CYCLES`, 64: busy duration after clear or home; must be ≥ 32.

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `lcd_word`  in  11: bus word, with fields {RS[10], RW[9], E[8], D[7:0]}.
- `busy`  out  1: busy flag.
- `rd_data`  out  8: read-back value.
- `rd_valid`  out  1: one-cycle pulse when `rd_data` updates.
- `cursor`  out  7: current DDRAM address (AC).
- `display_on`  out  1: D bit from the last display control command.
- `two_line`  out  1: N bit from the last function set command.
- `cmd_count`  out  8: accepted strobes, wrapping at 255→0.
- `err`  out  1: sticky flag; set when a strobe arrives while busy.
- `dbg_idx`  in  5: DDRAM cell index; 0–15 = line 0, 16–31 = line 1.
- `dbg_char`  out  8: combinational read of the DDRAM cell at `dbg_idx`.

## Operation
- **Strobe capture.** E is registered every cycle, together with RS, RW and D.
  - A strobe is a falling edge of E: the registered E is 1 and the current E is 0.
  - The command uses the RS/RW/D values registered on the last cycle E was high.
- **State machine:** INIT_FILL, IDLE, EXEC, CLEAR_FILL.
  - Reset goes to INIT_FILL, which writes 0x20 into all 32 cells, one per cycle, then goes to IDLE.
  - IDLE: a strobe with `busy`=0 executes the command and starts the busy counter.
  - EXEC: counts down from BUSY_CYCLES; when the count reaches 0 it returns to IDLE.
  - CLEAR_FILL: fills the DDRAM with 0x20 for the first 32 cycles, then holds busy until CLEAR_CYCLES have elapsed, then returns to IDLE.
- **Decode when RS=0, RW=0** (the highest set bit wins):
  - 1xxxxxxx: set AC to D[6:0]. Legal ranges are 0x00–0x0F and 0x40–0x4F; any other value is forced to 0x00 and sets `err`.
  - 001xxxxx: function set; `two_line` takes D[3].
  - 00001xxx: display control; `display_on` takes D[2].
  - 000001xx: entry mode; the internal I/D bit takes D[1]. The shift bit is ignored.
  - 0000001x: home. AC=0; enters CLEAR_FILL timing without filling the DDRAM.
  - 00000001: clear. AC=0, I/D=1; enters CLEAR_FILL.
  - 0x00: no-op; still counts in `cmd_count` and still causes busy.
- **RS=1, RW=0:** write D to the cell at AC, then step AC by I/D.
- **Cursor stepping.**
  - Increment wraps 0x0F→0x40 and 0x4F→0x00.
  - Decrement wraps 0x00→0x4F and 0x40→0x0F.
- **Cell mapping:** index = {AC[6], AC[3:0]}.
- **Reads.** Reads are accepted even while busy, do not start busy, and do not set `err`.
  - RS=0, RW=1: `rd_data` = {busy, AC}.
  - RS=1, RW=1: `rd_data` = the cell at AC, then AC steps.
- **Busy violation.** A write strobe while busy is ignored, except that it sets `err` and increments `cmd_count`.

## Timing
- **Reset values:**
  - `busy`=1 (INIT_FILL), `rd_data`=0, `rd_valid`=0.
  - `cursor`=0, `display_on`=0, `two_line`=0, `cmd_count`=0, `err`=0.
  - I/D=1.
- **Busy edges:**
  - `busy` rises on the cycle after the strobe cycle.
  - INIT_FILL is 32 cycles after reset release.
  - After a normal write, `busy` drops exactly BUSY_CYCLES cycles after it rose.
- **Register updates:** AC, DDRAM and the control bits update on the cycle after the strobe.
- **Reads:** `rd_data` and `rd_valid` appear 1 cycle after the strobe.
- **Reset mid-operation:** asserting reset during CLEAR_FILL or EXEC aborts immediately and restarts INIT_FILL.
- **Back-to-back:** a strobe arriving on the exact cycle `busy` falls is accepted.

## Structure
- **Shared package `lcd_pkg`:**
  - Field bit positions RS=10, RW=9, E=8.
  - Command opcode masks.
  - Line base addresses 0x00 and 0x40.
  - Fill character 0x20.
  - The state enum.
- **Sub-module `lcd_ddram`:** 32x8 storage, one synchronous write port and two combinational read ports (AC and `dbg_idx`).

## Test plan
- **Power-up:** release reset. `busy` stays 1 for 32 cycles, then drops; every `dbg_char` reads 0x20; `cursor`=0.
- **Write and wrap:** set AC 0x0E, then write 'A', 'B', 'C'.
  - Cells 14 and 15 hold 0x41 and 0x42; cell 16 holds 0x43.
  - `cursor`=0x41.
- **Decrement mode:** entry mode 0x04, set AC 0x00, write 'Z'. Cell 0 = 0x5A, `cursor`=0x4F.
- **Busy violation:** write 'X' during busy. DDRAM is unchanged, `err`=1, `cmd_count` increments.
- **Clear mid-text:** after text is written, send 0x01.
  - `busy` holds for CLEAR_CYCLES; all cells read 0x20; `cursor`=0.
  - A busy-flag read during the clear returns 0x80.
- **Full sequencer run:** drive the sequencer with an init table (0x38, 0x0C, 0x06, 0x01) plus "HOLA".
  - `two_line`=1, `display_on`=1, cells 0–3 = "HOLA".
  - `cmd_count`=8, `err`=0.
